mul_control: RTL and testbench
==============================

MUL_CONTROL -- requirements
Module: mul_control

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, single clock domain.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: start  input  1  multiply request, sampled in IDLE only.
REQ-004 SHALL have port: Multiplicand  input  32  unsigned operand A, captured on accept.
REQ-005 SHALL have port: Multiplier  input  32  unsigned operand B, captured on accept.
REQ-006 SHALL have port: Hi  input  32  upper half of the product register, from the product stage.
REQ-007 SHALL have port: Prod_lsb  input  1  bit 0 of the product register, from the product stage.
REQ-008 SHALL have port: run  output  1  enable to the product stage.
REQ-009 SHALL have port: Mul  output  32  latched multiplier, to the product stage.
REQ-010 SHALL have port: ALU_result  output  33  adder result, to the product stage.
REQ-011 SHALL have port: busy  output  1  high in LOAD and RUN.
REQ-012 SHALL have port: ready  output  1  one-cycle done pulse.
REQ-013 SHALL have port: cnt  output  6  iteration counter.

Function
REQ-014 SHALL implement the FSM states IDLE, LOAD, RUN and DONE, all registered.
REQ-015 IDLE with start=1 at the edge SHALL capture Multiplicand into the internal Mcand register, capture Multiplier into Mul, and go to LOAD.
REQ-016 IDLE with start=0 SHALL hold all registers.
REQ-017 LOAD SHALL last exactly 1 cycle (product-stage initial load) and then go to RUN with cnt=0.
REQ-018 RUN SHALL increment cnt by 1 per cycle; after the cycle with cnt=31 it SHALL go to DONE.
REQ-019 RUN SHALL therefore last exactly 32 cycles.
REQ-020 run SHALL be 1 in LOAD and RUN and 0 in IDLE and DONE: exactly 33 consecutive high cycles per operation.
REQ-021 DONE SHALL assert ready=1 for exactly 1 cycle and then go to IDLE.
REQ-022 ready SHALL be 0 in every other state.
REQ-023 busy SHALL be 1 in LOAD and RUN and 0 otherwise.
REQ-024 start SHALL be ignored in LOAD, RUN and DONE.
REQ-025 No new operation SHALL begin before the FSM returns to IDLE.
REQ-026 Mcand and Mul SHALL remain stable from accept until the next accept.
REQ-027 ALU_result SHALL be combinational: Prod_lsb=1 gives {1'b0,Hi} + {1'b0,Mcand}; Prod_lsb=0 gives {1'b0,Hi}.
REQ-028 ALU_result bit 32 SHALL carry the addition carry-out, with no truncation.
REQ-029 cnt SHALL hold its value in DONE (32) and be cleared to 0 on the next accept.
REQ-030 Operand values 0 and 32'hFFFFFFFF SHALL need no special handling; the sequence length is fixed.

Reset
REQ-031 rst=0 SHALL take effect immediately, without waiting for clk, in any state including mid-RUN.
REQ-032 While rst=0 the block SHALL hold state=IDLE, run=0, busy=0, ready=0, cnt=0, Mul=0, Mcand=0.
REQ-033 ALU_result SHALL therefore follow {1'b0,Hi} or {1'b0,Hi} until the next accept.
REQ-034 After rst returns to 1, the first clk edge SHALL evaluate IDLE; start high at that edge SHALL be accepted.

Verification
REQ-035 Bench SHALL cover basic operation: A=3, B=5, one-cycle start -> busy next cycle, run high 33 cycles, cnt 0..31 in RUN, single ready pulse at cycle 34 after accept, Mul=5 throughout.
REQ-036 Bench SHALL cover adder carry: Mcand=32'hFFFFFFFF, Hi=32'h00000001, Prod_lsb=1 -> ALU_result=33'h100000000; Prod_lsb=0 -> 33'h000000001.
REQ-037 Bench SHALL cover start while busy: pulse start with A=7, B=9 at RUN cnt=10 -> no restart, Mcand/Mul unchanged, ready still exactly 33 cycles after LOAD entry.
REQ-038 Bench SHALL cover asynchronous reset mid-RUN: rst low between clk edges at cnt=20 -> run, busy, cnt fall to 0 immediately, no ready pulse; a new start after release gives a full 33-cycle run.
REQ-039 Bench SHALL cover back-to-back operations: start held high continuously -> IDLE one cycle after each DONE, re-accept, ready pulses exactly 35 cycles apart.
REQ-040 Bench SHALL cover end-to-end operation with the product stage: A=32'hFFFFFFFF, B=32'hFFFFFFFF -> product 64'hFFFFFFFE00000001 at ready.

Source files
------------

// File: rtl/mul_control.sv
// Sequencer for a 32-cycle shift-add multiplier: latches the operands,
// drives the product stage and supplies the 33-bit partial-sum adder.
module mul_control (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] Multiplicand,
  input  logic [31:0] Multiplier,
  input  logic [31:0] Hi,
  input  logic        Prod_lsb,
  output logic        run,
  output logic [31:0] Mul,
  output logic [32:0] ALU_result,
  output logic        busy,
  output logic        ready,
  output logic [5:0]  cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mul_q, mul_d;
  logic [5:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mul_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mul_q   <= mul_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    mul_d   = mul_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          mcand_d = Multiplicand;
          mul_d   = Multiplier;
          cnt_d   = '0;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    run   = (state_q == LOAD) || (state_q == RUN);
    busy  = run;
    ready = (state_q == DONE);
    Mul   = mul_q;
    cnt   = cnt_q;
    // carry-out lands in bit 32 for the shift into the product register
    ALU_result = {1'b0, Hi}
               + (Prod_lsb ? {1'b0, mcand_q} : 33'd0);
  end

endmodule

// File: tb/tb_mul_control.sv
// Self-checking bench for mul_control with a shift-add product stage
// model, directed sequences, a vector table and a random reference model.
module tb_mul_control;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] A, B;
  logic [31:0] Hi;
  logic        Prod_lsb;
  logic        run;
  logic [31:0] Mul;
  logic [32:0] ALU_result;
  logic        busy;
  logic        ready;
  logic [5:0]  cnt;

  logic [31:0] hi_drv;
  logic        lsb_drv;
  logic        use_ps;
  logic [63:0] P;
  logic        run_d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_control dut (
    .clk(clk), .rst(rst), .start(start),
    .Multiplicand(A), .Multiplier(B),
    .Hi(Hi), .Prod_lsb(Prod_lsb),
    .run(run), .Mul(Mul), .ALU_result(ALU_result),
    .busy(busy), .ready(ready), .cnt(cnt)
  );

  always_comb begin
    Hi       = use_ps ? P[63:32] : hi_drv;
    Prod_lsb = use_ps ? P[0] : lsb_drv;
  end

  // product stage: load {0,Mul} on the first run cycle, then shift-add
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      P     <= '0;
      run_d <= 1'b0;
    end else begin
      run_d <= run;
      if (run && !run_d) P <= {32'd0, Mul};
      else if (run) P <= {ALU_result, P[31:1]};
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one full operation; k counts cycles since the accepting edge
  task automatic op(input logic [31:0] a, input logic [31:0] b,
                    input bit intr);
    int runs;
    int rdy;
    logic [63:0] prod;
    logic [5:0] ec;
    prod = {32'd0, a} * {32'd0, b};
    use_ps = 1'b1;
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    runs = 0; rdy = 0;
    for (int k = 1; k <= 36; k++) begin
      ec = (k == 1) ? 6'd0 : (k <= 33) ? 6'(k - 2) : 6'd32;
      chk("busy", 64'(busy), 64'(k <= 33));
      chk("run", 64'(run), 64'(k <= 33));
      chk("ready", 64'(ready), 64'(k == 34));
      chk("cnt", 64'(cnt), 64'(ec));
      chk("mul", 64'(Mul), 64'(b));
      if (run) runs++;
      if (ready) rdy++;
      if (k == 34) chk("product", P, prod);
      if (intr && k == 12) begin
        A = 32'd7; B = 32'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    chk("run_cycles", 64'(runs), 64'd33);
    chk("ready_pulses", 64'(rdy), 64'd1);
    use_ps = 1'b0; hi_drv = 32'd0; lsb_drv = 1'b1;
    #1;
    chk("mcand_kept", 64'(ALU_result), {31'd0, 1'b0, a});
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] hi;
    logic        lsb;
    logic [32:0] alu;
  } vec_t;

  vec_t vt[6];

  int mk;
  logic [31:0] mmc, mmu;
  logic [5:0] mce;
  int rt[$];
  int waited;
  logic [31:0] cur_a;

  initial begin
    vt[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 33'h100000000};
    vt[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h000000001};
    vt[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 33'h1FFFFFFFE};
    vt[3] = '{32'h00000000, 32'hFFFFFFFF, 1'b1, 33'h0FFFFFFFF};
    vt[4] = '{32'h12345678, 32'h00000001, 1'b1, 33'h012345679};
    vt[5] = '{32'h80000000, 32'h80000000, 1'b1, 33'h100000000};

    rst = 1'b0; start = 1'b0; A = '0; B = '0;
    use_ps = 1'b0; hi_drv = 32'd7; lsb_drv = 1'b1;
    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_run", 64'(run), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_cnt", 64'(cnt), 64'd0);
    chk("rst_mul", 64'(Mul), 64'd0);
    chk("rst_alu", 64'(ALU_result), 64'd7);
    @(negedge clk);
    rst = 1'b1;

    op(32'd3, 32'd5, 1'b0);
    op(32'd11, 32'd13, 1'b1);

    cur_a = 32'd11;
    for (int i = 0; i < 6; i++) begin
      if (vt[i].a !== cur_a) begin
        op(vt[i].a, $urandom, 1'b0);
        cur_a = vt[i].a;
      end
      use_ps = 1'b0;
      hi_drv = vt[i].hi; lsb_drv = vt[i].lsb;
      #1;
      chk($sformatf("alu_vec%0d", i), 64'(ALU_result), 64'(vt[i].alu));
    end

    // asynchronous reset in the middle of RUN
    use_ps = 1'b1;
    A = 32'd21; B = 32'd22; start = 1'b1;
    tick();
    start = 1'b0;
    waited = 0;
    while (cnt != 6'd20 && waited < 40) begin
      tick();
      waited++;
    end
    chk("reach_cnt20", 64'(cnt), 64'd20);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_run", 64'(run), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_cnt", 64'(cnt), 64'd0);
    chk("arst_mul", 64'(Mul), 64'd0);
    use_ps = 1'b0; hi_drv = 32'd5; lsb_drv = 1'b1;
    #1;
    chk("arst_alu", 64'(ALU_result), 64'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_noready", 64'(ready), 64'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    op(32'h0000BEEF, 32'h00001234, 1'b0);

    // start held high: back-to-back operations
    use_ps = 1'b1;
    A = 32'd100; B = 32'd200; start = 1'b1;
    for (int t = 0; t < 150 && rt.size() < 3; t++) begin
      tick();
      if (ready) rt.push_back(t);
    end
    start = 1'b0;
    chk("b2b_pulses", 64'(rt.size()), 64'd3);
    if (rt.size() == 3) begin
      chk("b2b_gap1", 64'(rt[1] - rt[0]), 64'd35);
      chk("b2b_gap2", 64'(rt[2] - rt[1]), 64'd35);
    end
    waited = 0;
    while ((busy || ready) && waited < 80) begin
      tick();
      waited++;
    end
    chk("b2b_idle", 64'(busy || ready), 64'd0);

    op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    op(32'h00000000, 32'hFFFFFFFF, 1'b0);

    // random stimulus against a cycle-count reference model
    rst = 1'b0;
    #2;
    rst = 1'b1;
    use_ps = 1'b0;
    mk = 0; mmc = '0; mmu = '0; mce = '0;
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 3) == 0);
      A = $urandom; B = $urandom;
      hi_drv = $urandom; lsb_drv = 1'($urandom);
      @(posedge clk);
      if (mk == 0) begin
        if (start) begin
          mk = 1; mmc = A; mmu = B; mce = '0;
        end
      end else if (mk == 34) begin
        mk = 0;
      end else begin
        mk++;
        mce = (mk >= 2) ? 6'(mk - 2) : 6'd0;
      end
      #1;
      chk("rnd_busy", 64'(busy), 64'(mk >= 1 && mk <= 33));
      chk("rnd_ready", 64'(ready), 64'(mk == 34));
      chk("rnd_cnt", 64'(cnt), 64'(mce));
      chk("rnd_mul", 64'(Mul), 64'(mmu));
      chk("rnd_alu", 64'(ALU_result),
          64'({1'b0, hi_drv} + (lsb_drv ? {1'b0, mmc} : 33'd0)));
    end
    start = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
